// File: rtl/wb_sched_if.sv
// Write-back scheduler bus: two producer handshakes (A = ALU, B = load) plus the
// registered register-file write port they are funnelled onto.
interface wb_sched_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8
);
    logic                  a_valid;
    logic                  a_ready;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [WIDTH-1:0]      a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [WIDTH-1:0]      b_data;
    logic                  rwb_we;
    logic [ADDR_WIDTH-1:0] rwb_addr;
    logic [WIDTH-1:0]      rwb_data;

    // Producer/register-file side.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rwb_we, rwb_addr, rwb_data
    );

    // Scheduler side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rwb_we, rwb_addr, rwb_data
    );
endinterface

// File: rtl/wb_sched.sv
// Write-back scheduler: arbitrates ALU/load results onto the register-file write
// port and tracks pending writes. Define WB_RR_EN for round-robin collisions.
module wb_sched #(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    wb_sched_if.slave                    bus,
    input  logic                         stall,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  a_pri;
    logic                  a_grant;
    logic                  b_grant;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;
    logic [NREG-1:0]       busy_q;
    logic [NREG-1:0]       busy_nxt;

`ifdef WB_RR_EN
    // last_b high means B took the most recent transfer, so A wins the next collision.
    logic last_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b0;
        end else if (fire) begin
            last_b <= b_grant;
        end
    end

    always_comb a_pri = last_b;
`else
    always_comb a_pri = 1'b0;
`endif

    always_comb begin
        a_grant  = rst_n & ~stall & bus.a_valid & (~bus.b_valid | a_pri);
        b_grant  = rst_n & ~stall & bus.b_valid & ~(bus.a_valid & a_pri);
        fire     = a_grant | b_grant;
        win_addr = b_grant ? bus.b_addr : bus.a_addr;
        win_data = b_grant ? bus.b_data : bus.a_data;
    end

    assign bus.a_ready = a_grant;
    assign bus.b_ready = b_grant;

    // Writes to x0 complete the handshake but leave the port (and its held values) alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rwb_we   <= 1'b0;
            bus.rwb_addr <= '0;
            bus.rwb_data <= '0;
        end else begin
            bus.rwb_we <= fire && (win_addr != '0);
            if (fire && (win_addr != '0)) begin
                bus.rwb_addr <= win_addr;
                bus.rwb_data <= win_data;
            end
        end
    end

    // Clear on commit first, then set, so a same-edge reissue stays pending.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.rwb_we) begin
            busy_nxt[bus.rwb_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;
endmodule
